// File: rtl/pong_pkg.sv
// Shared defaults and width helpers for the Pong score keeper.
package pong_pkg;

    localparam int unsigned PONG_N_PLAYERS = 2;
    localparam int unsigned PONG_WIN_SCORE = 5;

    function automatic int unsigned score_w(input int unsigned win_score);
        return $clog2(win_score + 1);
    endfunction

    // A single player still needs a 1-bit winner index.
    function automatic int unsigned idx_w(input int unsigned n_players);
        return (n_players > 1) ? $clog2(n_players) : 1;
    endfunction

endpackage

// File: rtl/score_channel.sv
// One player's score: rising-edge detect, saturating counter, point pulse and one-hot decode.
module score_channel
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE = PONG_WIN_SCORE,
    parameter int unsigned SCORE_W   = score_w(WIN_SCORE)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               point_i,
    input  logic               game_over_i,
    input  logic               new_game_i,
    output logic [SCORE_W-1:0] score_o,
    output logic [WIN_SCORE:0] onehot_o,
    output logic               pulse_o,
    output logic               hit_win_o
);

    logic               prev_q, prev_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               pulse_q, pulse_d;
    logic               inc;

    always_comb begin
        prev_d  = point_i;
        inc     = point_i & ~prev_q & ~game_over_i & ~new_game_i
                  & (score_q != SCORE_W'(WIN_SCORE));
        score_d = score_q;
        if (new_game_i) begin
            score_d = '0;
        end else if (inc) begin
            score_d = score_q + SCORE_W'(1);
        end
        pulse_d   = inc;
        hit_win_o = inc && (score_d == SCORE_W'(WIN_SCORE));
    end

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k <= int'(WIN_SCORE); k++) begin
            onehot_o[k] = (score_q == SCORE_W'(k));
        end
    end

    // History resets high so a strobe held through reset release never scores.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= 1'b1;
            score_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
        end
    end

    assign score_o = score_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/pong_score_keeper.sv
// N-player Pong score keeper: per-player channels plus win/tie arbitration and game-over FSM.
module pong_score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned N_PLAYERS = PONG_N_PLAYERS,
    parameter int unsigned WIN_SCORE = PONG_WIN_SCORE,
    parameter int unsigned SCORE_W   = score_w(WIN_SCORE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_PLAYERS-1:0]                 point_in,
    input  logic                                 new_game,
    output logic [N_PLAYERS*SCORE_W-1:0]         score_bin,
    output logic [N_PLAYERS*(WIN_SCORE+1)-1:0]   score_onehot,
    output logic [N_PLAYERS-1:0]                 point_pulse,
    output logic                                 game_over,
    output logic [idx_w(N_PLAYERS)-1:0]          winner,
    output logic                                 tie
);

    localparam int unsigned WINNER_W = idx_w(N_PLAYERS);
    localparam int unsigned OH_W     = WIN_SCORE + 1;

    typedef enum logic [0:0] {StPlay, StOver} state_e;

    state_e                state_q, state_d;
    logic [WINNER_W-1:0]   winner_q, winner_d;
    logic                  tie_q, tie_d;
    logic [N_PLAYERS-1:0]  hit_win;
    logic                  over;

    assign over = (state_q == StOver);

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_chan
        score_channel #(
            .WIN_SCORE (WIN_SCORE),
            .SCORE_W   (SCORE_W)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (rst),
            .point_i     (point_in[i]),
            .game_over_i (over),
            .new_game_i  (new_game),
            .score_o     (score_bin[i*SCORE_W +: SCORE_W]),
            .onehot_o    (score_onehot[i*OH_W +: OH_W]),
            .pulse_o     (point_pulse[i]),
            .hit_win_o   (hit_win[i])
        );
    end

    always_comb begin
        int unsigned hits;
        hits     = 0;
        state_d  = state_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        if (new_game) begin
            state_d  = StPlay;
            winner_d = '0;
            tie_d    = 1'b0;
        end else if (state_q == StPlay && |hit_win) begin
            state_d = StOver;
            // Scan downward so the lowest winning index is the one kept.
            for (int i = int'(N_PLAYERS) - 1; i >= 0; i--) begin
                if (hit_win[i]) begin
                    winner_d = WINNER_W'(i);
                    hits     = hits + 1;
                end
            end
            tie_d = (hits > 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StPlay;
            winner_q <= '0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
        end
    end

    assign game_over = over;
    assign winner    = winner_q;
    assign tie       = tie_q;

endmodule
